// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo
// Brief    : Single-clock FIFO with programmable almost-full/almost-empty
//            thresholds, registered read data and sticky error flags.
// Revision : 1.0
// ============================================================================
module param_sync_fifo #(
    parameter int DATA_W     = 10,
    parameter int ADDR_W     = 3,
    parameter int AF_DEFAULT = 6,
    parameter int AE_DEFAULT = 2,
    parameter bit DROP_ZERO  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [ADDR_W:0]   af_th,
    input  logic [ADDR_W:0]   ae_th,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              alm_full,
    output logic              alm_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_FULL_CNT = (ADDR_W + 1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_AF_RST   = (ADDR_W + 1)'(AF_DEFAULT);
    localparam logic [ADDR_W:0] c_AE_RST   = (ADDR_W + 1)'(AE_DEFAULT);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_af_th;
    logic [ADDR_W:0]   r_ae_th;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_rd_en;
    logic              w_wr_en;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    // Zero words are filtered before any full/overflow decision is made.
    assign w_push_ok = push && (!DROP_ZERO || (data_in != '0));
    assign w_rd_en   = pop && !w_empty;
    assign w_wr_en   = w_push_ok && (!w_full || w_rd_en);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_af_th     <= c_AF_RST;
            r_ae_th     <= c_AE_RST;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_rd_en) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_valid    <= 1'b1;
            end else begin
                r_valid    <= 1'b0;
            end

            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - 1'b1;
            end

            if (cfg_load) begin
                r_af_th <= af_th;
                r_ae_th <= ae_th;
            end

            if (w_push_ok && w_full && !w_rd_en) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign alm_full  = (r_count >= r_af_th);
    assign alm_empty = (r_count <= r_ae_th);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
